// File: rtl/pmt_pkg.sv
// Shared types and defaults for the PMT photon-counting channels.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pmt_pkg;

    // Default photon count width and gate-length width.
    localparam int CNT_W_DEF  = 16;
    localparam int GATE_W_DEF = 24;

    // Gate counter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } pmt_state_e;

endpackage : pmt_pkg

// File: rtl/pmt_pulse_sync.sv
// Synchronises a raw PMT discriminator pulse and emits a one-cycle rising-edge strobe.
// Latency: strobe is high in the 2nd cycle after the first clock edge that samples the pulse high.
// Backpressure: none; the strobe is free-running and must be consumed or dropped by the caller.
module pmt_pulse_sync (
    input  logic clock_i,
    input  logic reset_i,
    input  logic pmt_i,
    output logic evt_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two metastability flops followed by a delayed copy used for edge detection.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pmt_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // A rising edge on the synchronised level gives exactly one strobe cycle.
    assign evt_o = s2_q & ~s3_q;

endmodule : pmt_pulse_sync

// File: rtl/pmt_gate_counter.sv
// Counts synchronised PMT rising edges over a programmable gate window and offers the result.
// Latency: result valid gate_len+1 cycles after the accepted start; next start one cycle after handshake.
// Backpressure: result held stable while count_ready is low; start requests are dropped while busy.
module pmt_gate_counter
    import pmt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pmt_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    input  logic              count_ready,
    output logic              overflow
);

    pmt_state_e        state_q, state_d;
    logic [GATE_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  acc_q,   acc_d;
    logic              ovf_q,   ovf_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ovf_out_q, ovf_out_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;

    logic              evt;
    logic              acc_sat;
    logic [CNT_W-1:0]  acc_nxt;
    logic              ovf_nxt;

    pmt_pulse_sync u_sync (
        .clock_i (clock),
        .reset_i (reset),
        .pmt_i   (pmt_in),
        .evt_o   (evt)
    );

    // Saturating accumulate of this cycle's event; an increment lost at the ceiling flags overflow.
    always_comb begin
        acc_sat = &acc_q;
        acc_nxt = acc_q;
        ovf_nxt = ovf_q;
        if (evt) begin
            if (acc_sat) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc_q + CNT_W'(1);
            end
        end
    end

    // Window control: open on a non-zero start, count until the timer expires, hold until consumed.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        ovf_out_d = ovf_out_q;
        valid_d   = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (gate_len != '0)) begin
                    state_d = ST_COUNT;
                    timer_d = gate_len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_COUNT: begin
                timer_d = timer_q - GATE_W'(1);
                acc_d   = acc_nxt;
                ovf_d   = ovf_nxt;
                // The timer==1 cycle is the last counted one, so its event goes into the result.
                if (timer_q == GATE_W'(1)) begin
                    state_d   = ST_HOLD;
                    cnt_d     = acc_nxt;
                    ovf_out_d = ovf_nxt;
                    valid_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (valid_q && count_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and result registers; reset abandons any open window without producing a result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign count_out   = cnt_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_out_q;

endmodule : pmt_gate_counter
